demux32_1to4_buf: RTL and testbench

//  Inverse of the 32-bit 4:1 select path: routes one 32-bit producer word to one of four

---
 rtl/demux32_1to4_buf_pkg.sv | 13 +
 rtl/demux32_1to4_buf_slot.sv | 25 ++
 rtl/demux32_1to4_buf.sv | 55 +++++
 tb/tb_demux32_1to4_buf.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/demux32_1to4_buf_pkg.sv
// Shared constants and types for the 1:4 buffered word demux.
package demux32_1to4_buf_pkg;
  localparam int NUM_CH    = 4;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 8;

  typedef logic [1:0] sel_t;

  localparam sel_t CH0 = 2'd0;
  localparam sel_t CH1 = 2'd1;
  localparam sel_t CH2 = 2'd2;
  localparam sel_t CH3 = 2'd3;
endpackage

// File: rtl/demux32_1to4_buf_slot.sv
// One-entry holding register for a single consumer channel.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             drain_rdy,
  output logic [WIDTH-1:0] q,
  output logic             full
);
  // A load wins over a drain in the same cycle, so pass-through keeps the slot full.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (full && drain_rdy) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/demux32_1to4_buf.sv
// Routes one producer word to one of four buffered consumer channels with valid/ready.
module demux32_1to4_buf
  import demux32_1to4_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] accept_cnt
);
  logic [NUM_CH-1:0]            full;
  logic [NUM_CH-1:0]            load;
  logic [NUM_CH-1:0][WIDTH-1:0] slotQ;
  logic                         accept;

  // Ready only looks at the targeted channel; a draining target accepts in the same cycle.
  assign in_ready = !full[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : gSlot
    assign load[i] = accept & (in_sel == sel_t'(i));

    demux_slot #(.WIDTH(WIDTH)) uSlot (
      .Clk       (Clk),
      .Reset     (Reset),
      .load      (load[i]),
      .d         (in_data),
      .drain_rdy (out_ready[i]),
      .q         (slotQ[i]),
      .full      (full[i])
    );
  end

  assign out_valid = full;
  assign out_data0 = slotQ[CH0];
  assign out_data1 = slotQ[CH1];
  assign out_data2 = slotQ[CH2];
  assign out_data3 = slotQ[CH3];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       accept_cnt <= '0;
    else if (accept) accept_cnt <= accept_cnt + 1'b1;
  end
endmodule

// File: tb/tb_demux32_1to4_buf.sv
// Directed, table-driven check of the buffered 1:4 demux.
module tb_demux32_1to4_buf;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  accept_cnt;

  int compared   = 0;
  int mismatched = 0;

  demux32_1to4_buf dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .accept_cnt (accept_cnt)
  );

  always #5 Clk = ~Clk;

  // Producer must hold its word while stalled at an edge.
  logic        stallQ = 1'b0;
  logic [31:0] dataQ;
  logic [1:0]  selQ;
  always @(posedge Clk) begin
    if (!Reset && stallQ && in_valid && (in_data !== dataQ || in_sel !== selQ))
      $error("producer changed word while stalled");
    stallQ <= in_valid & ~in_ready & ~Reset;
    dataQ  <= in_data;
    selQ   <= in_sel;
  end

  function automatic logic [31:0] outData(input int ch);
    case (ch)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ordy;
    logic        expRdy;
    logic [3:0]  expVld;
    logic [7:0]  expCnt;
    int          chkCh;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] sb [4];
    logic [31:0] w;

    vecs[0]  = '{1'b1, 2'd1, 32'hDEADBEEF, 4'b0000, 1'b1, 4'b0010, 8'd1, 1, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 2'd1, 32'hCAFEF00D, 4'b0000, 1'b0, 4'b0010, 8'd1, 1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 2'd1, 32'h00000000, 4'b0000, 1'b0, 4'b0010, 8'd1, 1, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 2'd1, 32'h00000005, 4'b0010, 1'b1, 4'b0010, 8'd2, 1, 32'h00000005};
    vecs[4]  = '{1'b1, 2'd0, 32'hAAAA0000, 4'b0000, 1'b1, 4'b0011, 8'd3, 0, 32'hAAAA0000};
    vecs[5]  = '{1'b1, 2'd3, 32'h11111111, 4'b1000, 1'b1, 4'b1011, 8'd4, 3, 32'h11111111};
    vecs[6]  = '{1'b1, 2'd3, 32'h22222222, 4'b1000, 1'b1, 4'b1011, 8'd5, 3, 32'h22222222};
    vecs[7]  = '{1'b1, 2'd0, 32'hBBBB0000, 4'b1000, 1'b0, 4'b0011, 8'd5, 0, 32'hAAAA0000};
    vecs[8]  = '{1'b0, 2'd0, 32'h00000000, 4'b0010, 1'b0, 4'b0001, 8'd5, 1, 32'h00000005};
    vecs[9]  = '{1'b0, 2'd3, 32'h00000000, 4'b1111, 1'b1, 4'b0000, 8'd5, 3, 32'h22222222};
    vecs[10] = '{1'b1, 2'd2, 32'h12345678, 4'b0000, 1'b1, 4'b0100, 8'd6, 2, 32'h12345678};

    Reset = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset accept_cnt", 32'(accept_cnt), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk("reset out_data3", out_data3, 32'h0);
    Reset = 1'b0;

    // Single-cycle vectors: offer, stall, pass-through, independent channels.
    for (int v = 0; v < 11; v++) begin
      in_valid = vecs[v].vld; in_sel = vecs[v].sel;
      in_data = vecs[v].data; out_ready = vecs[v].ordy;
      #1;
      chk($sformatf("v%0d in_ready", v), 32'(in_ready), 32'(vecs[v].expRdy));
      @(posedge Clk); #1;
      chk($sformatf("v%0d out_valid", v), 32'(out_valid), 32'(vecs[v].expVld));
      chk($sformatf("v%0d accept_cnt", v), 32'(accept_cnt), 32'(vecs[v].expCnt));
      chk($sformatf("v%0d out_data%0d", v, vecs[v].chkCh), outData(vecs[v].chkCh), vecs[v].expData);
    end

    // Async reset mid-cycle with ch2 full clears state before any edge.
    in_valid = 1'b0; out_ready = '0;
    #2 Reset = 1'b1;
    #1;
    chk("async out_valid", 32'(out_valid), 32'h0);
    chk("async out_data2", out_data2, 32'h0);
    chk("async accept_cnt", 32'(accept_cnt), 32'h0);
    chk("async in_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h0BAD0BAD;
    @(posedge Clk); #1;
    chk("reset hold out_valid", 32'(out_valid), 32'h0);
    chk("reset hold accept_cnt", 32'(accept_cnt), 32'h0);
    in_valid = 1'b0;
    Reset = 1'b0;

    // Full-rate round-robin stream; 256 accepts wrap the counter back to zero.
    out_ready = 4'b1111;
    for (int i = 0; i < 256; i++) begin
      w = (32'(i) * 32'h01030507) ^ 32'hA5A50000;
      in_valid = 1'b1; in_sel = 2'(i % 4); in_data = w;
      sb[i % 4] = w;
      #1;
      chk($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'h1);
      @(posedge Clk); #1;
      chk($sformatf("stream%0d out_data%0d", i, i % 4), outData(i % 4), sb[i % 4]);
      chk($sformatf("stream%0d out_valid", i), 32'(out_valid[i % 4]), 32'h1);
    end
    chk("stream wrap accept_cnt", 32'(accept_cnt), 32'h0);

    // Load ch0 while ch3 still holds the last stream word, then idle with toggling inputs.
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hC0FFEE00; out_ready = 4'b0000;
    @(posedge Clk); #1;
    chk("preidle out_valid", 32'(out_valid), 32'h9);
    chk("preidle accept_cnt", 32'(accept_cnt), 32'h1);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b0; in_sel = 2'(c); in_data = 32'(c) * 32'h10101010;
      out_ready = 4'b0110;
      @(posedge Clk); #1;
      chk($sformatf("idle%0d out_valid", c), 32'(out_valid), 32'h9);
      chk($sformatf("idle%0d accept_cnt", c), 32'(accept_cnt), 32'h1);
      chk($sformatf("idle%0d out_data0", c), out_data0, 32'hC0FFEE00);
    end
    chk("idle out_data3", out_data3, sb[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
